ov7670_sccb_config: RTL and testbench

- Self-contained OV7670 camera configuration engine: a fixed register table sequencer feeding an SCCB (I2C-like, write-only) serializer.
- After reset or `resend`, writes every table entry to the camera over `sioc`/`siod`, then raises `config_finished`.
- Sits beside the camera capture path and is driven by the system pixel clock.

---
 rtl/ov7670_sccb_config.sv | 243 ++++++++++++++++++++++++
 tb/tb_ov7670_sccb_config.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config
// OV7670 camera configuration engine: a fixed {register, value} table
// sequencer feeding a write-only SCCB serializer on sioc/siod.
// After rst or resend every table entry is written as one 3-byte frame
// (CAM_ID, register, value); config_finished is high while the table
// pointer sits on the 16'hFFFF end marker.
// Optional feature, macro OV7670_DELAY_MARKER_EN: a 16'hF0F0 entry sends
// no frame and instead pauses for DELAY_CYCLES idle cycles (table index 1
// becomes such a post-reset settle marker).

module ov7670_sccb_config #(
    parameter logic [7:0]  CAM_ID       = 8'h42,
    parameter int unsigned QUARTER      = 63,
    parameter logic [23:0] DELAY_CYCLES = 24'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic resend,
    output logic config_finished,
    output logic taken,
    output logic sioc,
    inout  wire  siod
);

    localparam int             QW         = (QUARTER == 0) ? 1 : $clog2(QUARTER + 1);
    localparam logic [QW-1:0]  QMAX       = QW'(QUARTER);
    localparam logic [4:0]     LAST_SLOT  = 5'd30;
    localparam logic [15:0]    END_MARKER = 16'hFFFF;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    // Register table; anything past the end marker also reads as the marker.
    function automatic logic [15:0] rom_entry(input logic [4:0] a);
        case (a)
            5'd0:    rom_entry = 16'h1280;
`ifdef OV7670_DELAY_MARKER_EN
            5'd1:    rom_entry = 16'hF0F0;
`else
            5'd1:    rom_entry = 16'h1280;
`endif
            5'd2:    rom_entry = 16'h1204;
            5'd3:    rom_entry = 16'h1100;
            5'd4:    rom_entry = 16'h0C00;
            5'd5:    rom_entry = 16'h3E00;
            5'd6:    rom_entry = 16'h8C00;
            5'd7:    rom_entry = 16'h0400;
            5'd8:    rom_entry = 16'h40D0;
            5'd9:    rom_entry = 16'h3A04;
            5'd10:   rom_entry = 16'h1438;
            5'd11:   rom_entry = 16'h4F40;
            5'd12:   rom_entry = 16'h5034;
            5'd13:   rom_entry = 16'h510C;
            5'd14:   rom_entry = 16'h5217;
            5'd15:   rom_entry = 16'h5329;
            5'd16:   rom_entry = 16'h5440;
            5'd17:   rom_entry = 16'h581E;
            5'd18:   rom_entry = 16'h3DC0;
            default: rom_entry = END_MARKER;
        endcase
    endfunction

    // Bit of the latched 24-bit word carried by a data slot, MSB first:
    // slots 1-8 -> bits 23..16, 10-17 -> 15..8, 19-26 -> 7..0.
    function automatic logic [4:0] bit_index(input logic [4:0] s);
        if (s <= 5'd8)
            bit_index = 5'd24 - s;
        else if (s <= 5'd17)
            bit_index = 5'd25 - s;
        else
            bit_index = 5'd26 - s;
    endfunction

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [4:0]  addr;
    logic [15:0] command;
    logic        finished;
    logic        send;

    logic [0:0]    state, state_nxt;
    logic [4:0]    slot, slot_nxt;
    logic [1:0]    quarter, quarter_nxt;
    logic [QW-1:0] cnt, cnt_nxt;
    logic [23:0]   word, word_nxt;
    logic          load;
    logic          taken_nxt;
    logic          sioc_nxt, sda_nxt, oe_nxt;
    logic          sda_out, sda_oe;

    assign command         = rom_entry(addr);
    assign finished        = (command == END_MARKER);
    assign config_finished = finished;

`ifdef OV7670_DELAY_MARKER_EN
    logic        is_delay;
    logic        delay_done;
    logic [23:0] delay_cnt;

    assign is_delay   = (command == 16'hF0F0);
    assign delay_done = is_delay && (state == ST_IDLE) &&
                        (delay_cnt == DELAY_CYCLES - 24'd1);
    assign send       = ~finished & ~is_delay;

    // Delay timer: runs only while the serializer is idle on a marker, so
    // the pause is added after the preceding frame, never overlapped with it.
    always_ff @(posedge clk) begin
        if (rst || resend)
            delay_cnt <= '0;
        else if (delay_done)
            delay_cnt <= '0;
        else if (is_delay && (state == ST_IDLE))
            delay_cnt <= delay_cnt + 24'd1;
    end
`else
    assign send = ~finished;
`endif

    // Table pointer: restart has priority over advancing; the pointer parks
    // on the end marker because send (and thus taken) stays low there.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge, independent of block order.
        if (rst || resend)
            addr <= '0;
        else if (taken)
            addr <= addr + 5'd1;
`ifdef OV7670_DELAY_MARKER_EN
        else if (delay_done)
            addr <= addr + 5'd1;
`endif
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------

    // Next-state: accept a command when idle, then walk slot/quarter/cycle.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a branch that
        // skipped one would otherwise infer a latch.
        state_nxt   = state;
        slot_nxt    = slot;
        quarter_nxt = quarter;
        cnt_nxt     = cnt;
        taken_nxt   = 1'b0;
        load        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (send) begin
                    state_nxt   = ST_FRAME;
                    slot_nxt    = '0;
                    quarter_nxt = '0;
                    cnt_nxt     = '0;
                    taken_nxt   = 1'b1;
                    load        = 1'b1;
                end
            end
            default: begin
                if (cnt == QMAX) begin
                    cnt_nxt     = '0;
                    quarter_nxt = quarter + 2'd1;
                    if (quarter == 2'd3) begin
                        if (slot == LAST_SLOT) begin
                            state_nxt = ST_IDLE;
                            slot_nxt  = '0;
                        end else begin
                            slot_nxt = slot + 5'd1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + QW'(1);
                end
            end
        endcase
    end

    assign word_nxt = load ? {CAM_ID, command} : word;

    // Bus levels for the upcoming cycle, decoded from next state so that the
    // pins come straight from flops and cannot glitch.
    always_comb begin
        sioc_nxt = 1'b1;
        sda_nxt  = 1'b1;
        oe_nxt   = 1'b1;
        if (state_nxt == ST_FRAME) begin
            case (slot_nxt)
                5'd0: begin
                    sioc_nxt = (quarter_nxt != 2'd3);
                    sda_nxt  = (quarter_nxt == 2'd0);
                end
                5'd9, 5'd18, 5'd27: begin
                    sioc_nxt = quarter_nxt[1];
                    oe_nxt   = 1'b0;
                end
                5'd28: begin
                    sioc_nxt = (quarter_nxt != 2'd0);
                    sda_nxt  = quarter_nxt[1];
                end
                5'd29, 5'd30, 5'd31: begin
                end
                default: begin
                    sioc_nxt = quarter_nxt[1];
                    sda_nxt  = word_nxt[bit_index(slot_nxt)];
                end
            endcase
        end
    end

    // Control state and bus pins; reset drops straight to an idle-high bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            slot    <= '0;
            quarter <= '0;
            cnt     <= '0;
            taken   <= 1'b0;
            sioc    <= 1'b1;
            sda_out <= 1'b1;
            sda_oe  <= 1'b1;
        end else begin
            state   <= state_nxt;
            slot    <= slot_nxt;
            quarter <= quarter_nxt;
            cnt     <= cnt_nxt;
            taken   <= taken_nxt;
            sioc    <= sioc_nxt;
            sda_out <= sda_nxt;
            sda_oe  <= oe_nxt;
        end
    end

    // Frame word holding register.
    always_ff @(posedge clk) begin
        // NOTE: the word is deliberately not reset: it is only read during a
        // frame, and every frame begins by loading it.
        word <= word_nxt;
    end

    assign siod = sda_oe ? sda_out : 1'bz;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config
// Randomized self-checking bench for ov7670_sccb_config. A small reference
// model (table array + pointer) predicts which entry each frame carries; each
// frame is checked against a quarter-resolution waveform built from the SCCB
// frame layout and by protocol decoding (START/STOP, bytes on sioc rising).
// Honours OV7670_DELAY_MARKER_EN when the design is built with it.

module tb_ov7670_sccb_config;

    localparam int QUARTER = 3;
    localparam int QC      = QUARTER + 1;
    localparam int SLOT    = 4 * QC;
    localparam int FRAME   = 31 * SLOT;
    localparam int DELAY   = 100;
`ifdef OV7670_DELAY_MARKER_EN
    localparam int EXP_FRAMES = 18;
    localparam int PRE5       = 5;
    localparam int GAP_TOL    = 1;
`else
    localparam int EXP_FRAMES = 19;
    localparam int PRE5       = 6;
    localparam int GAP_TOL    = 0;
`endif

    localparam logic [15:0] TABLE [20] = '{
        16'h1280, 16'h1280, 16'h1204, 16'h1100, 16'h0C00,
        16'h3E00, 16'h8C00, 16'h0400, 16'h40D0, 16'h3A04,
        16'h1438, 16'h4F40, 16'h5034, 16'h510C, 16'h5217,
        16'h5329, 16'h5440, 16'h581E, 16'h3DC0, 16'hFFFF};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic resend = 1'b0;
    logic config_finished, taken, sioc;
    wire  siod;

    pullup (siod);

    ov7670_sccb_config #(
        .CAM_ID       (8'h42),
        .QUARTER      (QUARTER),
        .DELAY_CYCLES (24'(DELAY))
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .resend          (resend),
        .config_finished (config_finished),
        .taken           (taken),
        .sioc            (sioc),
        .siod            (siod)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_idx = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] tbl(input int i);
        if (i > 19) return 16'hFFFF;
`ifdef OV7670_DELAY_MARKER_EN
        if (i == 1) return 16'hF0F0;
`endif
        return TABLE[i];
    endfunction

    // Next frame the model expects; delay markers are skipped, adding pause.
    task automatic model_next(output logic [15:0] entry, output int extra);
        extra = 0;
        while (tbl(m_idx) == 16'hF0F0) begin
            m_idx++;
            extra += DELAY;
        end
        entry = tbl(m_idx);
    endtask

    // Expected quarter-by-quarter sioc/siod for one frame (slot 0 q0 at MSB).
    task automatic build_exp(input logic [23:0] w, output logic [123:0] ec, output logic [123:0] ed);
        logic [3:0] c, d;
        int pos;
        ec = '0;
        ed = '0;
        for (int s = 0; s < 31; s++) begin
            if (s == 0) begin
                c = 4'b1110; d = 4'b1000;
            end else if (s < 28) begin
                pos = s - 1;
                c = 4'b0011;
                if (pos % 9 == 8) d = 4'b1111;
                else d = {4{w[23 - 8 * (pos / 9) - (pos % 9)]}};
            end else if (s == 28) begin
                c = 4'b0111; d = 4'b0011;
            end else begin
                c = 4'b1111; d = 4'b1111;
            end
            ec = {ec[119:0], c};
            ed = {ed[119:0], d};
        end
    endtask

    // Starts at the negedge where taken was just seen (frame cycle 0); ends
    // at the negedge of the first cycle after the frame.
    task automatic run_frame(input logic [15:0] entry, input int resend_at);
        logic [123:0] ac, ad, ec, ed;
        logic c, d, c0, d0, pc, pd;
        logic [7:0] b_id, b_reg, b_val;
        bit bits[$];
        int unstable, starts, stops, extra_taken;
        ac = '0; ad = '0; c0 = 1'b1; d0 = 1'b1;
        pc = 1'b1; pd = 1'b1;
        unstable = 0; starts = 0; stops = 0; extra_taken = 0;
        for (int k = 0; k < FRAME; k++) begin
            c = sioc;
            d = siod;
            if (k % QC == 0) begin
                ac = {ac[122:0], c};
                ad = {ad[122:0], d};
                c0 = c;
                d0 = d;
            end else if (c !== c0 || d !== d0) begin
                unstable++;
            end
            if (!pc && c) bits.push_back(d);
            if (pc && c && pd && !d) starts++;
            if (pc && c && !pd && d) stops++;
            if (k > 0 && taken) extra_taken++;
            pc = c;
            pd = d;
            if (k == resend_at) resend = 1'b1;
            @(negedge clk);
            resend = 1'b0;
        end
        build_exp({8'h42, entry}, ec, ed);
        b_id = '0; b_reg = '0; b_val = '0;
        for (int i = 0; i < 8; i++) begin
            b_id  = {b_id[6:0],  bits.size() > i      ? bits[i]      : 1'b0};
            b_reg = {b_reg[6:0], bits.size() > i + 9  ? bits[i + 9]  : 1'b0};
            b_val = {b_val[6:0], bits.size() > i + 18 ? bits[i + 18] : 1'b0};
        end
        check("frame_sioc", ac, ec);
        check("frame_siod", ad, ed);
        check("quarter_stable", unstable, 0);
        check("start_count", starts, 1);
        check("stop_count", stops, 1);
        check("sioc_rises", bits.size(), 28);
        check("byte_id", b_id, 8'h42);
        check("byte_reg", b_reg, entry[15:8]);
        check("byte_val", b_val, entry[7:0]);
        check("taken_width", extra_taken, 0);
    endtask

    // Waits up to limit cycles for taken; bus must idle high meanwhile.
    task automatic wait_taken(input int limit, output int n);
        int bad;
        bad = 0;
        n = -1;
        for (int i = 0; i <= limit; i++) begin
            if (taken === 1'b1) begin
                n = i;
                break;
            end
            if (sioc !== 1'b1 || siod !== 1'b1) bad++;
            @(negedge clk);
        end
        check("idle_bus", bad, 0);
    endtask

    task automatic run_until_done(input int resend_idx, input int rst_idx, output int frames);
        logic [15:0] entry;
        int extra, n, k, len, want;
        frames = 0;
        model_next(entry, extra);
        forever begin
            if (m_idx == rst_idx) begin
                rst_idx = -1;
                k = 14 * SLOT + $urandom_range(0, SLOT - 1);
                len = $urandom_range(1, 3);
                repeat (k) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("rst_sioc", sioc, 1'b1);
                check("rst_siod", siod, 1'b1);
                check("rst_taken", taken, 1'b0);
                check("rst_cfg", config_finished, 1'b0);
                repeat (len - 1) @(negedge clk);
                rst = 1'b0;
                m_idx = 0;
                wait_taken(3, n);
                check("rst_restart_latency", n, 1);
                if (n < 0) break;
                model_next(entry, extra);
                continue;
            end
            if (m_idx == resend_idx) begin
                resend_idx = -1;
                run_frame(entry, $urandom_range(0, FRAME - 1));
                m_idx = 0;
            end else begin
                run_frame(entry, -1);
                m_idx++;
            end
            frames++;
            model_next(entry, extra);
            if (entry == 16'hFFFF) break;
            want = 1 + extra;
            wait_taken(want + 4, n);
            if (extra > 0)
                check("gap_delay_ok", (n >= want - GAP_TOL) && (n <= want + GAP_TOL), 1'b1);
            else
                check("gap", n, want);
            if (n < 0) break;
        end
    endtask

    task automatic resend_when_done();
        int n;
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        check("cfg_fall", config_finished, 1'b0);
        m_idx = 0;
        wait_taken(3, n);
        check("resend_latency", n, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, frames;
        repeat (3) @(negedge clk);
        check("reset_sioc", sioc, 1'b1);
        check("reset_siod", siod, 1'b1);
        check("reset_taken", taken, 1'b0);
        check("reset_cfg", config_finished, 1'b0);

        // Clean full run from reset release.
        rst = 1'b0;
        m_idx = 0;
        wait_taken(3, n);
        check("release_latency", n, 1);
        run_until_done(-1, -1, frames);
        check("frame_count", frames, EXP_FRAMES);
        check("cfg_done", config_finished, 1'b1);
        wait_taken($urandom_range(20, 200), n);
        check("quiet_after_done", n < 0, 1'b1);

        // Restart while finished, then resend in the middle of entry 5.
        resend_when_done();
        run_until_done(5, -1, frames);
        check("frame_count_resend", frames, PRE5 + EXP_FRAMES);
        check("cfg_done_resend", config_finished, 1'b1);

        // Restart again and abort one frame with rst in slot 14.
        resend_when_done();
        run_until_done(-1, $urandom_range(2, 18), frames);
        check("cfg_done_rst", config_finished, 1'b1);
        wait_taken($urandom_range(20, 100), n);
        check("quiet_after_rst_run", n < 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
